// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: drives the PC and pipeline-register enables, bubbles
// and flushes for load-use stalls, taken branches and data-memory wait states.
module pipeline_hazard_controller #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned WAIT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      IF_ID_instruction,
   input  logic             ID_EX_lw_control,
   input  logic [4:0]       ID_EX_rd,
   input  logic             EX_branch_control,
   input  logic             EX_branch_taken,
   input  logic             EX_MEM_mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_write,
   output logic             ID_EX_bubble,
   output logic             EX_MEM_write,
   output logic             MEM_WB_bubble,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_B = 7'b1100011;

   typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_fault_q, mem_fault_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;
   logic [CNT_W-1:0]  flush_count_q, flush_count_d;

   logic [6:0]        opcode;
   logic [4:0]        rs1, rs2;
   logic              rs1_used, rs2_used;
   logic              load_use, br_flush, mem_freeze;
   logic              stall_inc, flush_inc;
   logic [WAIT_W-1:0] wait_inc;
   logic              unused_instr_bits;

   assign opcode            = IF_ID_instruction[6:0];
   assign rs1               = IF_ID_instruction[19:15];
   assign rs2               = IF_ID_instruction[24:20];
   assign unused_instr_bits = ^{IF_ID_instruction[31:25], IF_ID_instruction[14:7]};

   // Which source fields the instruction in ID actually reads
   always_comb begin
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      case (opcode)
         OP_R, OP_S, OP_B: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OP_I, OP_L: rs1_used = 1'b1;
         default: ;
      endcase
   end

   assign load_use   = ID_EX_lw_control & (ID_EX_rd != 5'd0) &
                       ((rs1_used & (rs1 == ID_EX_rd)) | (rs2_used & (rs2 == ID_EX_rd)));
   assign br_flush   = EX_branch_control & EX_branch_taken;
   assign mem_freeze = EX_MEM_mem_req & ~mem_ready;

   // Mealy pipeline controls, priority reset > fault > freeze > flush > load-use > normal
   always_comb begin
      pc_write      = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_write   = 1'b1;
      ID_EX_bubble  = 1'b0;
      EX_MEM_write  = 1'b1;
      MEM_WB_bubble = 1'b0;
      if (rst) begin
         pc_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_write   = 1'b0;
         EX_MEM_write  = 1'b0;
         IF_ID_flush   = 1'b1;
         ID_EX_bubble  = 1'b1;
         MEM_WB_bubble = 1'b1;
      end else if ((state_q == FAULT) || mem_freeze) begin
         pc_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_write   = 1'b0;
         EX_MEM_write  = 1'b0;
         MEM_WB_bubble = 1'b1;
      end else if (br_flush) begin
         IF_ID_flush   = 1'b1;
         ID_EX_bubble  = 1'b1;
      end else if (load_use) begin
         pc_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_bubble  = 1'b1;
      end
   end

   // Performance counter events; a squashed load-use does not count as a stall
   assign stall_inc = (state_q != FAULT) & (mem_freeze | (~br_flush & load_use));
   assign flush_inc = (state_q != FAULT) & ~mem_freeze & br_flush;
   assign wait_inc  = (wait_cnt_q != '1) ? wait_cnt_q + WAIT_W'(1) : wait_cnt_q;

   // Next-state, wait counter, sticky fault and saturating counters
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_fault_d   = mem_fault_q;
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      case (state_q)
         RUN: begin
            if (mem_freeze) begin
               wait_cnt_d = WAIT_W'(1);
               if (MEM_TIMEOUT == 1) begin
                  state_d     = FAULT;
                  mem_fault_d = 1'b1;
               end else begin
                  state_d = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_inc;
               if ((MEM_TIMEOUT != 0) && (wait_inc == WAIT_W'(MEM_TIMEOUT))) begin
                  state_d     = FAULT;
                  mem_fault_d = 1'b1;
               end
            end
         end
         FAULT:   state_d = FAULT;
         default: state_d = RUN;
      endcase
      if (stall_inc && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
      if (flush_inc && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_fault_q   <= 1'b0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_fault_q   <= mem_fault_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign mem_fault   = mem_fault_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a main instance with a short
// memory timeout and a 2-bit-counter instance for saturation.
module tb_pipeline_hazard_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        lw;
   logic [4:0]  rd;
   logic        br, taken, req, ready;

   logic        pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, fault;
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_pc_w, s_ifid_w, s_ifid_f, s_idex_w, s_idex_b, s_exmem_w, s_memwb_b, s_fault;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
   localparam logic [6:0] C_RESET  = 7'b0010101;
   localparam logic [6:0] C_NORMAL = 7'b1101010;
   localparam logic [6:0] C_FREEZE = 7'b0000001;
   localparam logic [6:0] C_FLUSH  = 7'b1111110;
   localparam logic [6:0] C_STALL  = 7'b0001110;

   localparam logic [31:0] ADD_X6_X5_X7  = 32'h00728333;
   localparam logic [31:0] ADDI_X6_X1_7  = 32'h00708313;
   localparam logic [31:0] NOP           = 32'h00000013;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.CNT_W(16), .MEM_TIMEOUT(4), .WAIT_W(8)) u_dut (
      .clk(clk), .rst(rst), .IF_ID_instruction(instr), .ID_EX_lw_control(lw),
      .ID_EX_rd(rd), .EX_branch_control(br), .EX_branch_taken(taken),
      .EX_MEM_mem_req(req), .mem_ready(ready),
      .pc_write(pc_w), .IF_ID_write(ifid_w), .IF_ID_flush(ifid_f),
      .ID_EX_write(idex_w), .ID_EX_bubble(idex_b), .EX_MEM_write(exmem_w),
      .MEM_WB_bubble(memwb_b), .mem_fault(fault),
      .stall_count(stall_cnt), .flush_count(flush_cnt)
   );

   pipeline_hazard_controller #(.CNT_W(2), .MEM_TIMEOUT(64), .WAIT_W(8)) u_sat (
      .clk(clk), .rst(rst), .IF_ID_instruction(instr), .ID_EX_lw_control(lw),
      .ID_EX_rd(rd), .EX_branch_control(br), .EX_branch_taken(taken),
      .EX_MEM_mem_req(req), .mem_ready(ready),
      .pc_write(s_pc_w), .IF_ID_write(s_ifid_w), .IF_ID_flush(s_ifid_f),
      .ID_EX_write(s_idex_w), .ID_EX_bubble(s_idex_b), .EX_MEM_write(s_exmem_w),
      .MEM_WB_bubble(s_memwb_b), .mem_fault(s_fault),
      .stall_count(s_stall_cnt), .flush_count(s_flush_cnt)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] ctrl();
      return 32'({pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b});
   endfunction

   // Advance to the next falling edge, apply inputs, let combinational outputs settle
   task automatic cyc(input logic [31:0] i, input logic l, input logic [4:0] r,
                      input logic b, input logic t, input logic q, input logic y);
      @(negedge clk);
      instr = i; lw = l; rd = r; br = b; taken = t; req = q; ready = y;
      #1;
   endtask

   task automatic idle();
      cyc(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      instr = NOP; lw = 1'b0; rd = 5'd0; br = 1'b0; taken = 1'b0; req = 1'b0; ready = 1'b0;

      // Reset held two cycles
      idle();
      chk("reset_ctrl", ctrl(), 32'(C_RESET));
      idle();
      chk("reset_ctrl2", ctrl(), 32'(C_RESET));
      chk("reset_stall", 32'(stall_cnt), 32'd0);
      chk("reset_flush", 32'(flush_cnt), 32'd0);
      chk("reset_fault", 32'(fault), 32'd0);
      rst = 1'b0;
      idle();
      chk("post_reset_normal", ctrl(), 32'(C_NORMAL));

      // Load-use on rs1 (x5) stalls for one cycle
      cyc(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_rs1_stall", ctrl(), 32'(C_STALL));
      idle();
      chk("lu_rs1_release", ctrl(), 32'(C_NORMAL));
      chk("lu_rs1_count", 32'(stall_cnt), 32'd1);

      // Load to x0 never stalls
      cyc(ADD_X6_X5_X7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_x0_nostall", ctrl(), 32'(C_NORMAL));
      idle();
      chk("lu_x0_count", 32'(stall_cnt), 32'd1);

      // I-type ignores its rs2 field; R-type with rs2 match stalls
      cyc(ADDI_X6_X1_7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("itype_rs2_unused", ctrl(), 32'(C_NORMAL));
      cyc(ADD_X6_X5_X7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rtype_rs2_stall", ctrl(), 32'(C_STALL));
      idle();
      chk("rs2_count", 32'(stall_cnt), 32'd2);

      // Taken branch beats a simultaneous load-use
      cyc(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("br_flush_ctrl", ctrl(), 32'(C_FLUSH));
      cyc(NOP, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("br_not_taken", ctrl(), 32'(C_NORMAL));
      chk("br_flush_count", 32'(flush_cnt), 32'd1);
      chk("br_stall_unchanged", 32'(stall_cnt), 32'd2);

      // Three memory wait cycles, released together with a taken branch
      for (int k = 0; k < 3; k++) begin
         cyc(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("mem_freeze_%0d", k), ctrl(), 32'(C_FREEZE));
      end
      cyc(NOP, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("mem_release_flush", ctrl(), 32'(C_FLUSH));
      cyc(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("mem_ready_first_cycle", ctrl(), 32'(C_NORMAL));
      chk("mem_stall_count", 32'(stall_cnt), 32'd5);
      chk("mem_flush_count", 32'(flush_cnt), 32'd2);
      idle();
      chk("mem_no_extra_stall", 32'(stall_cnt), 32'd5);
      chk("mem_no_fault", 32'(fault), 32'd0);

      // Timeout after four consecutive wait cycles
      for (int k = 0; k < 4; k++) begin
         cyc(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("to_freeze_%0d", k), ctrl(), 32'(C_FREEZE));
         chk($sformatf("to_fault_%0d", k), 32'(fault), 32'd0);
      end
      cyc(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("to_fault_set", 32'(fault), 32'd1);
      chk("to_fault_ctrl", ctrl(), 32'(C_FREEZE));
      cyc(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("to_fault_holds", ctrl(), 32'(C_FREEZE));
      chk("to_stall_count", 32'(stall_cnt), 32'd9);
      idle();
      chk("to_fault_no_count", 32'(stall_cnt), 32'd9);
      chk("to_fault_no_flush", 32'(flush_cnt), 32'd2);

      // Reset clears the fault and the counters
      rst = 1'b1;
      idle();
      rst = 1'b0;
      idle();
      chk("rst_clears_fault", 32'(fault), 32'd0);
      chk("rst_clears_stall", 32'(stall_cnt), 32'd0);
      chk("rst_ctrl_normal", ctrl(), 32'(C_NORMAL));

      // Five stalls saturate a 2-bit counter at 3
      for (int k = 0; k < 5; k++) cyc(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      chk("sat_wide_count", 32'(stall_cnt), 32'd5);
      chk("sat_narrow_count", 32'(s_stall_cnt), 32'd3);
      chk("sat_narrow_ctrl", 32'({s_pc_w, s_ifid_w, s_ifid_f, s_idex_w, s_idex_b, s_exmem_w, s_memwb_b}),
          32'(C_NORMAL));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequences the 5-stage pipeline around the decode/control unit.
- Generates per-stage write-enable, bubble and flush controls.
- Handles load-use stalls, taken-branch flushes and data-memory wait states (with timeout).
- Sits beside the ID stage: it reads the IF_ID instruction plus ID_EX, EX and EX_MEM status, and drives the PC and pipeline-register enables.

Parameters:
CNT_W, 16, width of saturating performance counters stall_count and flush_count
MEM_TIMEOUT, 64, consecutive memory-wait cycles before fault; 0 disables timeout
WAIT_W, 8, width of internal wait counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
IF_ID_instruction  in  32  instruction currently in ID
ID_EX_lw_control  in  1  instruction in EX is a load
ID_EX_rd  in  5  destination register of instruction in EX
EX_branch_control  in  1  instruction in EX is a branch
EX_branch_taken  in  1  branch in EX resolved taken
EX_MEM_mem_req  in  1  instruction in MEM issues a data-memory read or write
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
IF_ID_write  out  1  IF_ID register load enable
IF_ID_flush  out  1  clear IF_ID to NOP
ID_EX_write  out  1  ID_EX register load enable
ID_EX_bubble  out  1  load NOP (all control zero) into ID_EX
EX_MEM_write  out  1  EX_MEM register load enable
MEM_WB_bubble  out  1  load NOP into MEM_WB
mem_fault  out  1  sticky memory-timeout flag
stall_count  out  CNT_W  saturating count of stall cycles
flush_count  out  CNT_W  saturating count of branch flushes

Behaviour:
Reset
- While rst=1: pc_write, IF_ID_write, ID_EX_write and EX_MEM_write = 0; IF_ID_flush, ID_EX_bubble and MEM_WB_bubble = 1.
- Reset loads state=RUN, wait_cnt=0, mem_fault=0 and both counters=0.
- rst overrides every state, including FAULT and mid-wait.

Register usage in ID (opcode = IF_ID_instruction[6:0])
- rs1 = [19:15]; used for R(0110011), I(0010011), L(0000011), S(0100011), B(1100011).
- rs2 = [24:20]; used for R, S and B only.
- Unknown opcodes use neither.

Combinational event terms
- load_use = ID_EX_lw_control & ID_EX_rd!=0 & ((rs1 used & rs1==ID_EX_rd) | (rs2 used & rs2==ID_EX_rd)).
- br_flush = EX_branch_control & EX_branch_taken.
- mem_freeze = EX_MEM_mem_req & ~mem_ready.

FSM states: RUN, MEM_WAIT, FAULT. Outputs are Mealy, with priority mem_freeze > br_flush > load_use > normal.
- Freeze (RUN or MEM_WAIT with mem_freeze=1): all write enables 0, MEM_WB_bubble=1, other bubbles and flush 0.
- Flush: all enables 1, IF_ID_flush=1, ID_EX_bubble=1. A load_use in the same cycle is ignored, because that instruction is squashed.
- Load-use stall: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, ID_EX_write=1, EX_MEM_write=1. Exactly one bubble cycle, since the load then moves to MEM.
- Normal: all enables 1; bubbles and flush 0.

Transitions
- RUN to MEM_WAIT on mem_freeze, with wait_cnt loaded to 1.
- MEM_WAIT: if mem_ready=1, go to RUN with wait_cnt=0. That cycle's outputs follow the non-freeze priority, so a pending branch or load-use is handled in the same cycle.
- MEM_WAIT otherwise: wait_cnt increments. If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT with mem_ready=0, go to FAULT and set mem_fault.
- A request with mem_ready=1 in its first cycle causes no stall.
- FAULT: all write enables 0; MEM_WB_bubble=1, other bubbles and flush 0. Remains until rst.

Counters
- stall_count +1 per freeze cycle and per load-use stall cycle.
- flush_count +1 per br_flush cycle taken (not during freeze).
- Both counters saturate at all-ones and never wrap.

Test Plan:
- Reset: hold rst 2 cycles → enables 0, bubbles/flush 1, counters 0, mem_fault 0; release → pc_write=1, all enables 1.
- Load-use stall: ID_EX_lw_control=1, ID_EX_rd=5, IF_ID_instruction=0x00728333 (add x6,x5,x7) → one cycle of pc_write=0, IF_ID_write=0, ID_EX_bubble=1, then stall_count=1. Repeat with ID_EX_rd=0 → no stall.
- rs2 not used: I-type 0x00708313 (addi x6,x1,7) with ID_EX_rd=7, lw=1 → no stall. Same rd with R-type using rs2=7 → stall.
- Branch priority: br_flush and load_use in the same cycle → IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; flush_count=1, stall_count unchanged.
- Memory wait: EX_MEM_mem_req=1 with mem_ready low for 3 cycles, then high → 3 freeze cycles (all enables 0, MEM_WB_bubble=1), release on the 4th cycle, stall_count=3, state back to RUN.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → mem_fault=1 after 4 wait cycles, enables stay 0 despite mem_ready=1 later; rst clears the fault. Also set CNT_W=2 and force 5 stalls → stall_count stays 3.
